codemem_loader: RTL and testbench
=================================

Name: codemem_loader

Overview:
- Sequences code-memory programming for one BPF VM and gates CPU instruction fetch.
- Accepts a program as a valid/ready instruction stream from the host side and writes it sequentially from address 0 into the code RAM's write port.
- Waits for the CPU to go idle before overwriting, and grants fetch access only while a complete program is resident.
- Sits between the host loader interface, the CPU fetch stage and the SDP code RAM. It drives every RAM port, including the shared clock enable.

Parameters:
ADDR_WIDTH, 10, code RAM address width
DATA_WIDTH, 64, instruction width
MAX_INSNS, 256, maximum program length in instructions; must be ≤ 2**ADDR_WIDTH

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
load_start  in  1  one-cycle pulse requesting a new program load
s_data  in  DATA_WIDTH  instruction beat
s_valid  in  1  beat valid
s_last  in  1  final instruction of the program
s_ready  out  1  beat accepted when s_valid & s_ready
cpu_idle  in  1  CPU not executing; safe to overwrite code
cpu_rd_en  in  1  CPU fetch request
cpu_rd_addr  in  ADDR_WIDTH  CPU program counter
prog_valid  out  1  complete program resident; CPU may run
prog_len  out  ADDR_WIDTH+1  instruction count of the resident program
load_err  out  1  last load overflowed MAX_INSNS
ram_en  out  1  code RAM clock enable
ram_wr_en  out  1  code RAM write enable
ram_wr_addr  out  ADDR_WIDTH  code RAM write address
ram_wr_data  out  DATA_WIDTH  code RAM write data
ram_rd_addr  out  ADDR_WIDTH  code RAM read address

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- Reset state is IDLE. Reset values: s_ready=0, prog_valid=0, prog_len=0, load_err=0, ram_wr_en=0, ram_en=0, write pointer=0.
- rst asserted mid-load aborts the load. The partially written RAM contents are left as-is, and prog_valid stays 0.

States:
- IDLE: no valid program. load_start moves to WAIT_CPU.
- WAIT_CPU: s_ready=0. When cpu_idle=1, move to LOAD, clear the write pointer and clear load_err.
- LOAD: s_ready=1. On each accepted beat, the same cycle drives ram_wr_en=1, ram_wr_addr=ptr and ram_wr_data=s_data (combinational from the handshake), then ptr increments.
  - Accepted beat with s_last=1: prog_len <= ptr+1; move to READY.
  - Accepted beat with s_last=0 and ptr==MAX_INSNS-1: that beat is written, then load_err <= 1 and move to SKIP.
- SKIP: s_ready=1. Beats are discarded with no RAM write. An accepted beat with s_last=1 moves to IDLE.
- READY: prog_valid=1. load_start moves to WAIT_CPU.

Flags and counts:
- prog_valid is registered: it is 1 exactly while the state is READY, and it falls the cycle after load_start is sampled in READY.
- prog_len holds its value until the next successful load; it is not cleared by load_start or by an error.
- load_err stays set until the next transition into LOAD or until rst.

Boundaries and ignored inputs:
- load_start is ignored in WAIT_CPU, LOAD and SKIP.
- s_valid is ignored outside LOAD and SKIP.
- A one-beat program (s_last on the first beat) is legal and gives prog_len=1.
- A program of exactly MAX_INSNS beats, with s_last on the last one, is legal and sets no error.
- cpu_idle dropping during LOAD has no effect, because the CPU must not run while prog_valid=0.

RAM read path:
- ram_rd_addr = cpu_rd_addr.
- ram_en = ram_wr_en | (cpu_rd_en & prog_valid).
- A fetch while prog_valid=0 does not enable the RAM, so rd_data holds its previous value.
- Read data appears one cycle after ram_en, which is the RAM's own latency; this block adds no latency on the read path.
- Reads and writes never overlap in time, because writes occur only while prog_valid=0.

Test Plan:
- Reset, then load_start with cpu_idle=1 and three beats A,B,C (C with s_last) -> writes to addresses 0,1,2 in the accept cycles; prog_valid rises the cycle after C; prog_len=3; load_err=0.
- With prog_valid=1, cpu_rd_en=1 and cpu_rd_addr=1 -> ram_en=1 and ram_rd_addr=1; with cpu_rd_en=1 while prog_valid=0 -> ram_en=0.
- load_start with cpu_idle=0 for 5 cycles -> s_ready stays 0, with no writes, for those 5 cycles; cpu_idle=1 -> s_ready=1 the next cycle; prog_len keeps its old value until the new s_last.
- MAX_INSNS=4, send 6 beats with s_last on beat 6 -> addresses 0-3 written, beats 5-6 discarded, load_err=1, final state IDLE, prog_valid=0.
- s_valid toggled 1,0,1,1 with s_last on the fourth cycle -> exactly 3 writes at addresses 0,1,2, and prog_len=3.
- rst pulsed mid-load after 2 beats -> all outputs return to reset values the next cycle; a following load_start restarts writing at address 0.

Source files
------------

// File: rtl/codemem_loader.sv
// -----------------------------------------------------------------------------
// codemem_loader
//
// Sequences code-memory programming for a single BPF VM and gates the CPU's
// instruction fetch. A program arrives as a valid/ready beat stream and is
// written from address 0 upward into the write port of a simple dual-port
// code RAM. Fetch access to the RAM is granted only while a complete program
// is resident.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   load_start           one-cycle pulse requesting a new program load
//   s_data/s_valid/      instruction beat stream from the host loader
//   s_last/s_ready
//   cpu_idle             CPU not executing; code may be overwritten
//   cpu_rd_en/addr       CPU fetch request and program counter
//   prog_valid           complete program resident; CPU may run
//   prog_len             instruction count of the resident program
//   load_err             last load overflowed MAX_INSNS
//   ram_*                every port of the code RAM (shared clock enable,
//                        write port, read address)
// -----------------------------------------------------------------------------
module codemem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_INSNS  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic                  cpu_idle,
    input  logic                  cpu_rd_en,
    input  logic [ADDR_WIDTH-1:0] cpu_rd_addr,
    output logic                  prog_valid,
    output logic [ADDR_WIDTH:0]   prog_len,
    output logic                  load_err,
    output logic                  ram_en,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr
);

    localparam int PW = ADDR_WIDTH + 1;
    // Pointer value of the last slot a program may occupy.
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_INSNS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CPU,
        S_LOAD,
        S_SKIP,
        S_READY
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   prog_len_q, prog_len_d;
    logic            load_err_q, load_err_d;
    logic            prog_valid_q, prog_valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            prog_len_q   <= '0;
            load_err_q   <= 1'b0;
            prog_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            prog_len_q   <= prog_len_d;
            load_err_q   <= load_err_d;
            prog_valid_q <= prog_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        prog_len_d = prog_len_q;
        load_err_d = load_err_q;

        case (state_q)
            S_IDLE: begin
                if (load_start) state_d = S_WAIT_CPU;
            end
            S_WAIT_CPU: begin
                if (cpu_idle) begin
                    state_d    = S_LOAD;
                    ptr_d      = '0;
                    load_err_d = 1'b0;
                end
            end
            S_LOAD: begin
                // s_ready is high for the whole state, so s_valid alone
                // marks an accepted beat.
                if (s_valid) begin
                    ptr_d = ptr_q + 1'b1;
                    if (s_last) begin
                        prog_len_d = ptr_q + 1'b1;
                        state_d    = S_READY;
                    end else if (ptr_q == LAST_PTR) begin
                        // Program does not fit: drain the rest of it.
                        load_err_d = 1'b1;
                        state_d    = S_SKIP;
                    end
                end
            end
            S_SKIP: begin
                if (s_valid && s_last) state_d = S_IDLE;
            end
            S_READY: begin
                if (load_start) state_d = S_WAIT_CPU;
            end
            default: state_d = S_IDLE;
        endcase

        // Registered copy of "next state is READY" so the flag tracks the
        // state exactly without a combinational decode on the output.
        prog_valid_d = (state_d == S_READY);
    end

    assign s_ready     = (state_q == S_LOAD) || (state_q == S_SKIP);
    assign ram_wr_en   = (state_q == S_LOAD) && s_valid;
    assign ram_wr_addr = ptr_q[ADDR_WIDTH-1:0];
    assign ram_wr_data = s_data;
    assign ram_rd_addr = cpu_rd_addr;
    // Writes only happen while prog_valid is low, so the two enable terms
    // never coincide and the shared clock enable is safe.
    assign ram_en      = ram_wr_en || (cpu_rd_en && prog_valid_q);

    assign prog_valid  = prog_valid_q;
    assign prog_len    = prog_len_q;
    assign load_err    = load_err_q;

endmodule

// File: tb/tb_codemem_loader.sv
module tb_codemem_loader;

    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int MAX = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic          cpu_idle;
    logic          cpu_rd_en;
    logic [AW-1:0] cpu_rd_addr;
    logic          prog_valid;
    logic [AW:0]   prog_len;
    logic          load_err;
    logic          ram_en;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [AW-1:0] ram_rd_addr;

    codemem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_INSNS(MAX)) dut (
        .clk(clk), .rst(rst), .load_start(load_start),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .cpu_idle(cpu_idle), .cpu_rd_en(cpu_rd_en), .cpu_rd_addr(cpu_rd_addr),
        .prog_valid(prog_valid), .prog_len(prog_len), .load_err(load_err),
        .ram_en(ram_en), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    // Reference model state: what the resident-program flags should read.
    int  exp_len = 0;
    bit  exp_err = 0;
    bit  exp_pv  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every RAM write must match the next expected write.
    always @(negedge clk) begin
        if (ram_wr_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_wr actual=addr %0h data %0h required=no write",
                         ram_wr_addr, ram_wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(ram_wr_addr), 64'(e.a));
                chk("wr_data", 64'(ram_wr_data), 64'(e.d));
                chk("wr_ram_en", 64'(ram_en), 64'd1);
                $display("write addr=%0d data=%08h", ram_wr_addr, ram_wr_data);
            end
        end
    end

    // Request a load; hold cpu_idle low for idle_delay cycles first.
    task automatic start_load(input int idle_delay);
        int k;
        cpu_idle   = 1'b0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        @(negedge clk);
        chk("pv_fall", 64'(prog_valid), 64'd0);
        chk("wait_s_ready", 64'(s_ready), 64'd0);
        for (int i = 0; i < idle_delay; i++) begin
            tick();
            s_valid     = 1'($urandom);   // must be ignored while waiting
            s_data      = $urandom;
            load_start  = 1'($urandom);   // ignored outside IDLE/READY
            cpu_rd_en   = 1'b1;
            cpu_rd_addr = AW'($urandom);
            @(negedge clk);
            chk("wait_s_ready", 64'(s_ready), 64'd0);
            chk("wait_len_hold", 64'(prog_len), 64'(exp_len));
            chk("wait_ram_en", 64'(ram_en), 64'd0);
        end
        tick();
        s_valid    = 1'b0;
        load_start = 1'b0;
        cpu_rd_en  = 1'b0;
        cpu_idle   = 1'b1;
        k = 0;
        while (k < 10) begin
            @(negedge clk);
            if (s_ready) break;
            tick();
            k++;
        end
        chk("ready_latency", 64'(k), 64'd1);
    endtask

    task automatic send_beat(input int idx, input bit last);
        tick();
        s_valid  = 1'b1;
        s_data   = $urandom;
        s_last   = last;
        cpu_idle = 1'($urandom);          // dropping idle mid-load is harmless
        if (idx < MAX) exp_q.push_back('{a: AW'(idx), d: s_data});
        @(negedge clk);
        chk("beat_s_ready", 64'(s_ready), 64'd1);
    endtask

    // Send an n-beat program; bit i of gap_mask inserts an idle cycle before beat i.
    task automatic send_program(input int n, input int gap_mask);
        for (int i = 0; i < n; i++) begin
            if (gap_mask[i]) begin
                tick();
                s_valid = 1'b0;
                s_data  = $urandom;
                s_last  = 1'($urandom);
            end
            send_beat(i, i == n - 1);
        end
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (n <= MAX) begin
            exp_len = n;
            exp_err = 0;
            exp_pv  = 1;
        end else begin
            exp_err = 1;
            exp_pv  = 0;
        end
        @(negedge clk);
        chk("prog_valid", 64'(prog_valid), 64'(exp_pv));
        chk("prog_len", 64'(prog_len), 64'(exp_len));
        chk("load_err", 64'(load_err), 64'(exp_err));
        chk("writes_drained", 64'(exp_q.size()), 64'd0);
        $display("program n=%0d prog_valid=%0b prog_len=%0d load_err=%0b",
                 n, prog_valid, prog_len, load_err);
    endtask

    task automatic check_reset_values();
        @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_prog_valid", 64'(prog_valid), 64'd0);
        chk("rst_prog_len", 64'(prog_len), 64'd0);
        chk("rst_load_err", 64'(load_err), 64'd0);
        chk("rst_ram_wr_en", 64'(ram_wr_en), 64'd0);
        chk("rst_ram_en", 64'(ram_en), 64'd0);
        exp_len = 0;
        exp_err = 0;
        exp_pv  = 0;
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
        cpu_idle = 1'b1; cpu_rd_en = 1'b1; cpu_rd_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_values();
        cpu_rd_en = 1'b0;

        // Basic three-beat program.
        start_load(0);
        send_program(3, 0);

        // Fetch gating while a program is resident.
        for (int i = 0; i < 6; i++) begin
            tick();
            cpu_rd_en   = 1'($urandom);
            cpu_rd_addr = AW'($urandom);
            @(negedge clk);
            chk("rd_ram_en", 64'(ram_en), 64'(cpu_rd_en));
            chk("rd_addr", 64'(ram_rd_addr), 64'(cpu_rd_addr));
        end
        tick();
        cpu_rd_en = 1'b0;

        // Busy CPU for 5 cycles, then a program with a gap (valid 1,0,1,1).
        start_load(5);
        send_program(3, 32'b010);

        // Exactly MAX beats: legal, no error.
        start_load(1);
        send_program(MAX, 0);

        // Overflow: MAX+2 beats.
        start_load(2);
        send_program(MAX + 2, int'($urandom));

        // One-beat program, reached from IDLE after the overflow.
        start_load(0);
        send_program(1, 0);

        // Reset in the middle of a load.
        start_load(0);
        send_beat(0, 1'b0);
        send_beat(1, 1'b0);
        tick();
        s_valid = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values();
        start_load(0);
        send_program(3, 0);

        // Random programs.
        for (int r = 0; r < 10; r++) begin
            start_load(int'($urandom_range(0, 3)));
            send_program(int'($urandom_range(1, MAX + 3)), int'($urandom));
        end

        repeat (3) tick();
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
